// File: rtl/of_pkg.sv
// Shared widths, decoded-field payload and hit helper for the operand fetch stage.
package of_pkg;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned NUM_REGS = 32;

  // Decoded instruction fields carried from decode through both fetch stages.
  typedef struct packed {
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              mem_read;
  } of_fields_t;

  // True when a register write targets a nonzero source register.
  function automatic logic wr_hit(input logic              wr_en,
                                  input logic [REG_AW-1:0] wr_rd,
                                  input logic [REG_AW-1:0] rs);
    return wr_en && (wr_rd == rs) && (rs != '0);
  endfunction

endpackage

// File: rtl/of_fwd_mux.sv
// Per-operand source select at the stage B output.
// With FORWARDING_EN defined the EX/MEM result is bypassed and a pending load
// flags a load-use stall; otherwise only the write-back bypass is present.
module of_fwd_mux
  import of_pkg::*;
(
  input  logic [REG_AW-1:0] rs_i,
  input  logic [DATA_W-1:0] held_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              ex_reg_write_i,
  input  logic              ex_mem_read_i,
  input  logic [DATA_W-1:0] ex_result_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  input  logic              wb_reg_write_i,
  input  logic [DATA_W-1:0] wb_data_i,
  output logic [DATA_W-1:0] op_o,
  output logic              load_use_o
);

`ifndef FORWARDING_EN
  logic unused_ex;
  assign unused_ex = ^{ex_rd_i, ex_reg_write_i, ex_mem_read_i, ex_result_i};
`endif

  // Priority: x0 -> 0, then EX/MEM, then write-back in flight, then held value.
  // The write-back bypass keeps an operand presented in the same cycle as its
  // register write from going out stale.
  always_comb begin
    op_o       = held_i;
    load_use_o = 1'b0;
    if (rs_i == '0) begin
      op_o = '0;
    end else begin
`ifdef FORWARDING_EN
      if (wr_hit(ex_reg_write_i, ex_rd_i, rs_i)) begin
        if (ex_mem_read_i) begin
          load_use_o = 1'b1;
        end else begin
          op_o = ex_result_i;
        end
      end else if (wr_hit(wb_reg_write_i, wb_rd_i, rs_i)) begin
        op_o = wb_data_i;
      end
`else
      if (wr_hit(wb_reg_write_i, wb_rd_i, rs_i)) begin
        op_o = wb_data_i;
      end
`endif
    end
  end

endmodule

// File: rtl/operand_fetch_stage.sv
// Two-stage operand fetch: A issues register-file reads and holds fields,
// B captures read data, resolves bypasses and presents the ID/EX payload.
// Macro FORWARDING_EN: defined -> EX/MEM bypass with load-use stall;
// undefined -> busy scoreboard blocks A until sources are written back.
module operand_fetch_stage
  import of_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] in_rs1,
  input  logic [REG_AW-1:0] in_rs2,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_reg_write,
  input  logic              in_mem_read,
  output logic [REG_AW-1:0] read_reg1,
  output logic [REG_AW-1:0] read_reg2,
  input  logic [DATA_W-1:0] read_data1,
  input  logic [DATA_W-1:0] read_data2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic [DATA_W-1:0] ex_result,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_reg_write,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_op1,
  output logic [DATA_W-1:0] out_op2,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_reg_write,
  output logic              out_mem_read
);

  of_fields_t        in_fields;
  of_fields_t        a_q, a_d, b_q, b_d;
  logic              a_valid_q, a_valid_d;
  logic              b_valid_q, b_valid_d;
  logic [DATA_W-1:0] b_op1_q, b_op1_d, b_op2_q, b_op2_d;
  logic              b_take1_q, b_take1_d, b_take2_q, b_take2_d;
  logic [DATA_W-1:0] held1, held2;
  logic              lu1, lu2;
  logic              b_fire, a_to_b, accept, a_block;

  assign in_fields = '{rs1: in_rs1, rs2: in_rs2, rd: in_rd,
                       reg_write: in_reg_write, mem_read: in_mem_read};

  // Read data is only valid in B's first cycle; afterwards the latched copy is used.
  assign held1 = b_take1_q ? read_data1 : b_op1_q;
  assign held2 = b_take2_q ? read_data2 : b_op2_q;

  of_fwd_mux u_fwd1 (
    .rs_i(b_q.rs1), .held_i(held1),
    .ex_rd_i(ex_rd), .ex_reg_write_i(ex_reg_write),
    .ex_mem_read_i(ex_mem_read), .ex_result_i(ex_result),
    .wb_rd_i(wb_rd), .wb_reg_write_i(wb_reg_write), .wb_data_i(wb_data),
    .op_o(out_op1), .load_use_o(lu1)
  );

  of_fwd_mux u_fwd2 (
    .rs_i(b_q.rs2), .held_i(held2),
    .ex_rd_i(ex_rd), .ex_reg_write_i(ex_reg_write),
    .ex_mem_read_i(ex_mem_read), .ex_result_i(ex_result),
    .wb_rd_i(wb_rd), .wb_reg_write_i(wb_reg_write), .wb_data_i(wb_data),
    .op_o(out_op2), .load_use_o(lu2)
  );

  assign out_valid     = b_valid_q && !(lu1 || lu2);
  assign b_fire        = out_valid && out_ready;
  assign a_to_b        = a_valid_q && (!b_valid_q || b_fire) && !a_block;
  assign in_ready      = !a_valid_q || a_to_b;
  assign accept        = in_valid && in_ready;
  assign read_reg1     = a_q.rs1;
  assign read_reg2     = a_q.rs2;
  assign out_rd        = b_q.rd;
  assign out_reg_write = b_q.reg_write;
  assign out_mem_read  = b_q.mem_read;

`ifdef FORWARDING_EN
  assign a_block = 1'b0;
`else
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic                b_wr_hit;

  // An instruction leaving B this cycle marks its rd busy at the same edge.
  assign b_wr_hit = b_fire && b_q.reg_write && (b_q.rd != '0) &&
                    ((b_q.rd == a_q.rs1) || (b_q.rd == a_q.rs2));
  assign a_block  = busy_q[a_q.rs1] || busy_q[a_q.rs2] || b_wr_hit;

  // Busy scoreboard: cleared by write-back, set by an issuing writer (set wins).
  always_comb begin
    busy_d = busy_q;
    if (wb_reg_write) begin
      busy_d[wb_rd] = 1'b0;
    end
    if (b_fire && b_q.reg_write && (b_q.rd != '0)) begin
      busy_d[b_q.rd] = 1'b1;
    end
  end

  // Scoreboard register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end
`endif

  // Next-state for both stages and B's operand capture.
  always_comb begin
    a_valid_d = a_valid_q;
    a_d       = a_q;
    b_valid_d = b_valid_q;
    b_d       = b_q;
    b_op1_d   = b_op1_q;
    b_op2_d   = b_op2_q;
    b_take1_d = b_take1_q;
    b_take2_d = b_take2_q;

    if (accept) begin
      a_valid_d = 1'b1;
      a_d       = in_fields;
    end else if (a_to_b) begin
      a_valid_d = 1'b0;
    end

    if (a_to_b) begin
      b_valid_d = 1'b1;
      b_d       = a_q;
      // The register file misses a write on the read edge, so take wb_data.
      if (wr_hit(wb_reg_write, wb_rd, a_q.rs1)) begin
        b_op1_d   = wb_data;
        b_take1_d = 1'b0;
      end else begin
        b_take1_d = 1'b1;
      end
      if (wr_hit(wb_reg_write, wb_rd, a_q.rs2)) begin
        b_op2_d   = wb_data;
        b_take2_d = 1'b0;
      end else begin
        b_take2_d = 1'b1;
      end
    end else if (b_fire) begin
      b_valid_d = 1'b0;
    end else if (b_valid_q) begin
      // Holding: freeze read data and absorb matching write-backs.
      b_op1_d   = wr_hit(wb_reg_write, wb_rd, b_q.rs1) ? wb_data : held1;
      b_op2_d   = wr_hit(wb_reg_write, wb_rd, b_q.rs2) ? wb_data : held2;
      b_take1_d = 1'b0;
      b_take2_d = 1'b0;
    end
  end

  // Stage registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_valid_q <= 1'b0;
      a_q       <= '0;
      b_valid_q <= 1'b0;
      b_q       <= '0;
      b_op1_q   <= '0;
      b_op2_q   <= '0;
      b_take1_q <= 1'b0;
      b_take2_q <= 1'b0;
    end else begin
      a_valid_q <= a_valid_d;
      a_q       <= a_d;
      b_valid_q <= b_valid_d;
      b_q       <= b_d;
      b_op1_q   <= b_op1_d;
      b_op2_q   <= b_op2_d;
      b_take1_q <= b_take1_d;
      b_take2_q <= b_take2_d;
    end
  end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Scoreboard bench for operand_fetch_stage with a synchronous-read register file model.
`timescale 1ns/1ps
module tb_operand_fetch_stage;
  import of_pkg::*;

  logic              clock = 1'b0;
  logic              reset;
  logic              in_valid, in_ready;
  logic [REG_AW-1:0] in_rs1, in_rs2, in_rd;
  logic              in_reg_write, in_mem_read;
  logic [REG_AW-1:0] read_reg1, read_reg2;
  logic [DATA_W-1:0] read_data1, read_data2;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_reg_write, ex_mem_read;
  logic [DATA_W-1:0] ex_result;
  logic [REG_AW-1:0] wb_rd;
  logic              wb_reg_write;
  logic [DATA_W-1:0] wb_data;
  logic              out_valid, out_ready;
  logic [DATA_W-1:0] out_op1, out_op2;
  logic [REG_AW-1:0] out_rd;
  logic              out_reg_write, out_mem_read;

  operand_fetch_stage dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_reg_write(in_reg_write), .in_mem_read(in_mem_read),
    .read_reg1(read_reg1), .read_reg2(read_reg2),
    .read_data1(read_data1), .read_data2(read_data2),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_result(ex_result),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op1(out_op1), .out_op2(out_op2), .out_rd(out_rd),
    .out_reg_write(out_reg_write), .out_mem_read(out_mem_read)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    logic [REG_AW-1:0] rd;
    logic              rw;
    logic              mr;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Register file preload values.
  function automatic logic [DATA_W-1:0] preload(input int i);
    case (i)
      2:       return 8'h20;
      3:       return 8'h99;
      4:       return 8'h40;
      5:       return 8'h3C;
      6:       return 8'h60;
      7:       return 8'h11;
      8:       return 8'h80;
      default: return 8'h00;
    endcase
  endfunction

  // Register file: data one cycle after address, writes not visible on the same edge.
  logic [DATA_W-1:0] rf [NUM_REGS];
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= preload(i);
      read_data1 <= '0;
      read_data2 <= '0;
    end else begin
      read_data1 <= rf[read_reg1];
      read_data2 <= rf[read_reg2];
      if (wb_reg_write && (wb_rd != '0)) rf[wb_rd] <= wb_data;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compare each output handshake with the oldest expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (!reset && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_output: got rd=%0d, expected no output", out_rd);
        end else begin
          e = exp_q.pop_front();
          chk("out_op1", 32'(out_op1), 32'(e.op1));
          chk("out_op2", 32'(out_op2), 32'(e.op2));
          chk("out_rd", 32'(out_rd), 32'(e.rd));
          chk("out_reg_write", 32'(out_reg_write), 32'(e.rw));
          chk("out_mem_read", 32'(out_mem_read), 32'(e.mr));
        end
      end
    end
  end

  task automatic issue(input logic [REG_AW-1:0] rs1, input logic [REG_AW-1:0] rs2,
                       input logic [REG_AW-1:0] rd, input logic rw, input logic mr,
                       input logic [DATA_W-1:0] e1, input logic [DATA_W-1:0] e2);
    int   cyc = 0;
    exp_t e;
    in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
    in_reg_write = rw; in_mem_read = mr; in_valid = 1'b1;
    @(negedge clock);
    while (!in_ready && cyc < 50) begin
      @(negedge clock);
      cyc++;
    end
    if (!in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL issue_timeout: in_ready got 0, expected 1 within 50 cycles");
    end else begin
      e.op1 = e1; e.op2 = e2; e.rd = rd; e.rw = rw; e.mr = mr;
      exp_q.push_back(e);
    end
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int cyc = 0;
    @(posedge clock);
    while (exp_q.size() != 0 && cyc < 100) begin
      @(posedge clock);
      cyc++;
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending outputs, expected 0", exp_q.size());
    end
    #1;
  endtask

  task automatic wb_pulse(input logic [REG_AW-1:0] rd, input logic [DATA_W-1:0] d);
    wb_reg_write = 1'b1; wb_rd = rd; wb_data = d;
    @(posedge clock);
    #1;
    wb_reg_write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
    in_reg_write = 1'b0; in_mem_read = 1'b0;
    ex_rd = '0; ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_result = '0;
    wb_rd = '0; wb_reg_write = 1'b0; wb_data = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clock);
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_read_reg1", 32'(read_reg1), 32'(0));
    chk("rst_out_op1", 32'(out_op1), 32'(0));
    chk("rst_out_rd", 32'(out_rd), 32'(0));
    @(posedge clock);
    #1;

    // Plain read with two-cycle latency: x5=0x3C, x0=0
    issue(5, 0, 1, 1'b0, 1'b0, 8'h3C, 8'h00);
    @(negedge clock);
    chk("latency_cycle1_valid", 32'(out_valid), 32'(0));
    @(negedge clock);
    chk("latency_cycle2_valid", 32'(out_valid), 32'(1));
    wait_drain();

    // Write-back on the A->B edge must beat the stale register file value
    issue(3, 0, 9, 1'b0, 1'b1, 8'h12, 8'h00);
    wb_pulse(3, 8'h12);
    wait_drain();

    // Write-back while B holds overwrites the held operand
    out_ready = 1'b0;
    issue(4, 6, 2, 1'b0, 1'b0, 8'h40, 8'h66);
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("hold_op2_before_wb", 32'(out_op2), 32'(8'h60));
    @(posedge clock);
    #1;
    wb_pulse(6, 8'h66);
    out_ready = 1'b1;
    wait_drain();

    // Backpressure with two queued instructions, then back-to-back release
    out_ready = 1'b0;
    issue(2, 8, 11, 1'b0, 1'b0, 8'h20, 8'h80);
    issue(5, 2, 12, 1'b1, 1'b1, 8'h3C, 8'h20);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk("stall_out_valid", 32'(out_valid), 32'(1));
      chk("stall_out_op1", 32'(out_op1), 32'(8'h20));
      chk("stall_out_op2", 32'(out_op2), 32'(8'h80));
      chk("stall_out_rd", 32'(out_rd), 32'(11));
      chk("stall_in_ready", 32'(in_ready), 32'(0));
    end
    @(posedge clock);
    #1 out_ready = 1'b1;
    @(negedge clock);
    chk("release_first_rd", 32'(out_rd), 32'(11));
    @(negedge clock);
    chk("release_second_valid", 32'(out_valid), 32'(1));
    chk("release_second_rd", 32'(out_rd), 32'(12));
    wait_drain();

`ifdef FORWARDING_EN
    // EX/MEM bypass of a non-load result
    ex_reg_write = 1'b1; ex_mem_read = 1'b0; ex_rd = 5; ex_result = 8'h77;
    issue(5, 0, 14, 1'b0, 1'b0, 8'h77, 8'h00);
    wait_drain();
    ex_reg_write = 1'b0;

    // Load-use stall for one cycle, then operand arrives via write-back
    ex_reg_write = 1'b1; ex_mem_read = 1'b1; ex_rd = 7; ex_result = 8'hEE;
    issue(0, 7, 15, 1'b0, 1'b0, 8'h00, 8'hA5);
    @(negedge clock);
    @(negedge clock);
    chk("load_use_out_valid", 32'(out_valid), 32'(0));
    @(posedge clock);
    #1;
    ex_reg_write = 1'b0; ex_mem_read = 1'b0;
    wb_reg_write = 1'b1; wb_rd = 7; wb_data = 8'hA5;
    @(negedge clock);
    chk("load_use_release_valid", 32'(out_valid), 32'(1));
    @(posedge clock);
    #1 wb_reg_write = 1'b0;
    wait_drain();
`else
    // Scoreboard: reader of x10 waits in A until x10 is written back
    issue(0, 0, 10, 1'b1, 1'b0, 8'h00, 8'h00);
    issue(10, 5, 13, 1'b0, 1'b0, 8'h5A, 8'h3C);
    repeat (4) @(negedge clock);
    chk("busy_out_valid", 32'(out_valid), 32'(0));
    chk("busy_in_ready", 32'(in_ready), 32'(0));
    @(posedge clock);
    #1;
    wb_pulse(10, 8'h5A);
    wait_drain();
`endif

    // Reset with both stages full discards everything
    out_ready = 1'b0;
    issue(2, 4, 16, 1'b1, 1'b1, 8'h20, 8'h40);
    issue(4, 2, 17, 1'b0, 1'b0, 8'h40, 8'h20);
    @(negedge clock);
    chk("pre_reset_out_rd", 32'(out_rd), 32'(16));
    reset = 1'b1;
    #1;
    chk("mid_reset_out_valid", 32'(out_valid), 32'(0));
    chk("mid_reset_out_op1", 32'(out_op1), 32'(0));
    chk("mid_reset_out_op2", 32'(out_op2), 32'(0));
    chk("mid_reset_out_rd", 32'(out_rd), 32'(0));
    chk("mid_reset_out_reg_write", 32'(out_reg_write), 32'(0));
    chk("mid_reset_out_mem_read", 32'(out_mem_read), 32'(0));
    chk("mid_reset_read_reg1", 32'(read_reg1), 32'(0));
    exp_q.delete();
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("post_reset_in_ready", 32'(in_ready), 32'(1));
    chk("post_reset_out_valid", 32'(out_valid), 32'(0));
    @(posedge clock);
    #1 out_ready = 1'b1;
    issue(5, 4, 18, 1'b0, 1'b0, 8'h3C, 8'h40);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
